// File: rtl/haar_idwt_recon_if.sv
// Coefficient-pair input and reconstructed-sample output bus for haar_idwt_recon.
// The master side drives coefficients and out_ready; the slave side is the reconstruction block.
interface haar_idwt_recon_if;
  logic signed [31:0] in_approx;
  logic signed [31:0] in_detail;
  logic               in_valid;
  logic               in_ready;
  logic signed [31:0] out_signal;
  logic               out_valid;
  logic               out_ready;
  logic               out_phase;
  logic        [15:0] out_count;

  modport master (
    output in_approx, in_detail, in_valid, out_ready,
    input  in_ready, out_signal, out_valid, out_phase, out_count
  );

  modport slave (
    input  in_approx, in_detail, in_valid, out_ready,
    output in_ready, out_signal, out_valid, out_phase, out_count
  );
endinterface

// File: rtl/haar_idwt_recon.sv
// One-level Haar inverse DWT: each (a, d) pair yields x[2n] = (a+d)/sqrt2, then x[2n+1] = (a-d)/sqrt2.
// Define HAAR_RECON_SAT_EN to saturate out-of-range samples instead of wrapping them.
module haar_idwt_recon #(
  parameter logic signed [15:0] COEFF = 16'sd5793,
  parameter int                 FRAC  = 13
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  haar_idwt_recon_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, EVEN, ODD} state_t;

  state_t             state, state_nx;
  logic signed [32:0] s, t;
  logic               phase, phase_nx;
  logic        [15:0] count;
  logic               ready_c;
  logic               accept, out_hs;
  logic signed [48:0] p_e, p_o;

  // Drop FRAC fraction bits; the top product bit supplies the sign of the Q2.29 result.
  function automatic logic [31:0] to_word(input logic signed [48:0] p);
`ifdef HAAR_RECON_SAT_EN
    logic signed [48:0] q;
    q = p >>> FRAC;
    if (q[48:31] != {18{q[31]}})
      return q[48] ? 32'h8000_0000 : 32'h7FFF_FFFF;
    return q[31:0];
`else
    return {p[48], p[FRAC+30:FRAC]};
`endif
  endfunction

  assign p_e = s * COEFF;
  assign p_o = t * COEFF;

  assign bus.in_ready   = rst & en & ready_c;
  assign accept         = bus.in_valid & bus.in_ready;
  assign out_hs         = bus.out_valid & bus.out_ready;
  assign bus.out_valid  = (state != IDLE);
  assign bus.out_phase  = phase;
  assign bus.out_count  = count;
  assign bus.out_signal = phase ? to_word(p_o) : to_word(p_e);

  // NOTE: every variable written here gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_nx = state;
    phase_nx = phase;
    ready_c  = 1'b0;
    unique case (state)
      IDLE: begin
        ready_c = 1'b1;
        if (bus.in_valid) begin
          state_nx = EVEN;
          phase_nx = 1'b0;
        end
      end
      EVEN: begin
        if (bus.out_ready) begin
          state_nx = ODD;
          phase_nx = 1'b1;
        end
      end
      ODD: begin
        // Taking the next pair while the odd sample leaves avoids a bubble cycle.
        ready_c = bus.out_ready;
        if (bus.out_ready) begin
          state_nx = bus.in_valid ? EVEN : IDLE;
          if (bus.in_valid) phase_nx = 1'b0;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      s     <= '0;
      t     <= '0;
      phase <= 1'b0;
      count <= '0;
    end else if (!en) begin
      state <= IDLE;
      s     <= '0;
      t     <= '0;
      phase <= 1'b0;
    end else begin
      state <= state_nx;
      phase <= phase_nx;
      if (accept) begin
        s <= {bus.in_approx[31], bus.in_approx} + {bus.in_detail[31], bus.in_detail};
        t <= {bus.in_approx[31], bus.in_approx} - {bus.in_detail[31], bus.in_detail};
      end
      if (out_hs) count <= count + 16'd1;
    end
  end

endmodule
